// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Line levels, FSM state encoding and a counter-width helper.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter; bit_end marks the last clock of each bit.
// Cleared on accept so the first bit of a frame gets its full length.
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned          CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Counts 0..CLKS_PER_BIT-1 and wraps; never passes the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Parallel word is captured on a valid/ready handshake; all outputs are flops.
module nibble_serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  idx_next;
    logic              tx_next;
    logic              busy_next;
    logic              ready_next;
    logic              done_next;
    logic              accept;
    logic              bit_end;

    assign accept = load_valid && load_ready;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .bit_end (bit_end)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            tx         <= TX_IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_idx    <= idx_next;
            tx         <= tx_next;
            busy       <= busy_next;
            done       <= done_next;
            load_ready <= ready_next;
        end
    end

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        idx_next   = bit_idx;
        done_next  = 1'b0;
        tx_next    = TX_IDLE_LEVEL;
        busy_next  = 1'b0;
        ready_next = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next = data;
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    // Index holds at its last value rather than overrunning.
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            IDLE: begin
                tx_next    = TX_IDLE_LEVEL;
                ready_next = 1'b1;
            end
            START: begin
                tx_next   = TX_START_LEVEL;
                busy_next = 1'b1;
            end
            DATA: begin
                tx_next   = shift_next[0];
                busy_next = 1'b1;
            end
            STOP: begin
                tx_next   = TX_IDLE_LEVEL;
                busy_next = 1'b1;
            end
            default: begin
                tx_next    = TX_IDLE_LEVEL;
                ready_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: default instance plus a one-clock-per-bit instance.
module tb_nibble_serial_tx;

    logic       clk;
    logic       reset;
    logic [3:0] data;
    logic       load_valid;
    logic       load_ready;
    logic       tx;
    logic       busy;
    logic       done;

    logic [3:0] data1;
    logic       load_valid1;
    logic       load_ready1;
    logic       tx1;
    logic       busy1;
    logic       done1;

    int n_checks;
    int n_errors;

    nibble_serial_tx dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    nibble_serial_tx #(
        .DATA_W       (4),
        .CLKS_PER_BIT (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .data       (data1),
        .load_valid (load_valid1),
        .load_ready (load_ready1),
        .tx         (tx1),
        .busy       (busy1),
        .done       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"},    32'(tx),         32'd1);
        check({tag, " busy"},  32'(busy),       32'd0);
        check({tag, " done"},  32'(done),       32'd0);
        check({tag, " ready"}, 32'(load_ready), 32'd1);
    endtask

    // Present a word for one edge; returns in cycle E+1.
    task automatic accept(input logic [3:0] word);
        data       = word;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    // Checks cycles E+1..E+25 of a default frame; optionally chains the next word
    // in the done cycle, or wiggles data/load_valid mid-frame.
    task automatic run_frame(input logic [3:0] word, input logic chain,
                             input logic [3:0] chain_word, input logic disturb);
        int   b;
        logic exp_tx;
        for (int n = 1; n <= 24; n++) begin
            b = (n - 1) / 4;
            if (b == 0)      exp_tx = 1'b0;
            else if (b == 5) exp_tx = 1'b1;
            else             exp_tx = word[b-1];
            check($sformatf("w%0h c%0d tx", word, n),    32'(tx),         32'(exp_tx));
            check($sformatf("w%0h c%0d busy", word, n),  32'(busy),       32'd1);
            check($sformatf("w%0h c%0d done", word, n),  32'(done),       32'd0);
            check($sformatf("w%0h c%0d ready", word, n), 32'(load_ready), 32'd0);
            if (disturb) begin
                if (n == 8) begin
                    data       = 4'h5;
                    load_valid = 1'b1;
                end
                if (n == 20) load_valid = 1'b0;
            end
            tick();
        end
        check($sformatf("w%0h c25 done", word),  32'(done),       32'd1);
        check($sformatf("w%0h c25 busy", word),  32'(busy),       32'd0);
        check($sformatf("w%0h c25 ready", word), 32'(load_ready), 32'd1);
        check($sformatf("w%0h c25 tx", word),    32'(tx),         32'd1);
        if (chain) begin
            data       = chain_word;
            load_valid = 1'b1;
            tick();
            load_valid = 1'b0;
        end
    endtask

    initial begin
        logic       saw_done;
        logic [5:0] seq1;

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        data        = 4'h0;
        load_valid  = 1'b0;
        data1       = 4'h0;
        load_valid1 = 1'b0;

        // Reset held two cycles, then idle.
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        check("reset dut1 tx", 32'(tx1), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_idle("idle");

        // Single frame 4'b1010.
        accept(4'b1010);
        run_frame(4'b1010, 1'b0, 4'h0, 1'b0);
        tick();
        check("single c26 done", 32'(done), 32'd0);
        check_idle("single after");

        // Back-to-back F then 0, second word accepted in the done cycle.
        accept(4'hF);
        run_frame(4'hF, 1'b1, 4'h0, 1'b0);
        run_frame(4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        check_idle("b2b after");

        // Mid-frame data change and load_valid are ignored.
        accept(4'hC);
        run_frame(4'hC, 1'b0, 4'h0, 1'b1);
        tick();
        check_idle("ignore after");
        tick();
        check_idle("ignore after2");

        // Reset during data bit 2 aborts the frame.
        accept(4'hA);
        for (int i = 0; i < 12; i++) tick();
        check("abort bit2 tx", 32'(tx), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        accept(4'h3);
        run_frame(4'h3, 1'b0, 4'h0, 1'b0);

        // Reset together with load_valid: word is not taken.
        tick();
        data       = 4'h9;
        load_valid = 1'b1;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        check_idle("reset vs valid");
        tick();
        check_idle("reset vs valid2");

        // One clock per bit: 0110 -> 0,0,1,1,0,1 then done.
        seq1        = 6'b101100;
        data1       = 4'b0110;
        load_valid1 = 1'b1;
        tick();
        load_valid1 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            check($sformatf("cpb1 c%0d tx", n),   32'(tx1),   32'(seq1[n-1]));
            check($sformatf("cpb1 c%0d busy", n), 32'(busy1), 32'd1);
            check($sformatf("cpb1 c%0d done", n), 32'(done1), 32'd0);
            tick();
        end
        check("cpb1 c7 done",  32'(done1),       32'd1);
        check("cpb1 c7 ready", 32'(load_ready1), 32'd1);
        tick();
        check("cpb1 c8 done",  32'(done1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
